// File: rtl/pokey_sio_link.sv
// Purpose : POKEY serial I/O shifter; 8N1 async transmit of SEROUT bytes, receive into SERIN.
// Latency : TX line drops one clock after acceptance, frame 10*BAUD_DIV; RX byte valid one clock after stop sample.
// Backpres: TX takes a byte only when idle (tx_rdy/tx_ack); RX holds one byte, later good bytes dropped as overrun.
//
// Ports:
//   clk_i, rst_ni                     single clock, asynchronous active-low reset
//   tx_data_i/tx_rdy_i/tx_ack_o       byte offer from POKEY SEROUT, 1-cycle ack when captured
//   tx_busy_o, sio_out_o              frame in progress, serial line out (idle high)
//   sio_in_i                          serial line in (asynchronous, idle high)
//   rx_data_o/rx_rdy_o/rx_ack_i       received byte to POKEY SERIN, 4-phase handshake
//   rx_frame_err_o, rx_overrun_o      1-cycle pulses, the offending byte is dropped
module pokey_sio_link #(
  parameter int BAUD_DIV = 79
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_rdy_i,
  output logic       tx_ack_o,
  output logic       tx_busy_o,
  output logic       sio_out_o,
  input  logic       sio_in_i,
  output logic [7:0] rx_data_o,
  output logic       rx_rdy_o,
  input  logic       rx_ack_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Counters run reload..0 inclusive, so a reload of N-1 gives an N-cycle bit.
  localparam logic [15:0] BIT_RELOAD  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2);

  // ---------------------------------------------------------------------------
  // Transmit
  // ---------------------------------------------------------------------------
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_ack_q, tx_ack_d;
  logic        tx_sio_q, tx_sio_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_ack_q   <= 1'b0;
      tx_sio_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_ack_q   <= tx_ack_d;
      tx_sio_q   <= tx_sio_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_ack_d   = 1'b0;
    tx_sio_d   = 1'b1;

    case (tx_state_q)
      S_IDLE: begin
        if (tx_rdy_i) begin
          tx_shift_d = tx_data_i;
          tx_cnt_d   = BIT_RELOAD;
          tx_bit_d   = 3'd0;
          tx_ack_d   = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = BIT_RELOAD;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = BIT_RELOAD;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so it changes on the same
    // edge as the FSM and never glitches.
    case (tx_state_d)
      S_START: tx_sio_d = 1'b0;
      S_DATA:  tx_sio_d = tx_shift_d[0];
      default: tx_sio_d = 1'b1;
    endcase
  end

  assign tx_ack_o  = tx_ack_q;
  assign tx_busy_o = (tx_state_q != S_IDLE);
  assign sio_out_o = tx_sio_q;

  // ---------------------------------------------------------------------------
  // Receive
  // ---------------------------------------------------------------------------
  // Synchronizer and edge-detect history reset high so that reset release on
  // an idle line is not mistaken for a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= sio_in_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        rx_ferr_q, rx_ferr_d;
  logic        rx_ovr_q, rx_ovr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    // Ack drops the valid flag; an ack with nothing pending has no effect.
    rx_rdy_d   = rx_rdy_q & ~rx_ack_i;
    rx_ferr_d  = 1'b0;
    rx_ovr_d   = 1'b0;

    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          // Wait half a bit so every later sample lands mid-bit.
          rx_cnt_d   = HALF_RELOAD;
          rx_bit_d   = 3'd0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;  // line went back high: glitch, not a start bit
          end else begin
            rx_cnt_d   = BIT_RELOAD;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_RELOAD;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          // Back to IDLE straight away so a following start edge inside the
          // remaining half stop bit is still caught.
          rx_state_d = S_IDLE;
          if (!rx_sync_q) begin
            rx_ferr_d = 1'b1;
          end else if (rx_rdy_q || rx_ack_i) begin
            // Previous byte not yet consumed (or the 4-phase ack is still
            // high): keep the old byte, flag the new one as lost.
            rx_ovr_d = 1'b1;
          end else begin
            rx_data_d = rx_shift_q;
            rx_rdy_d  = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign rx_data_o      = rx_data_q;
  assign rx_rdy_o       = rx_rdy_q;
  assign rx_frame_err_o = rx_ferr_q;
  assign rx_overrun_o   = rx_ovr_q;

endmodule

// File: tb/tb_pokey_sio_link.sv
module tb_pokey_sio_link;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       tx_ack;
  logic       tx_busy;
  logic       sio_out;
  logic       sio_drv;
  logic       loop_en;
  logic       sio_in;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;
  logic       rx_ferr;
  logic       rx_ovr;

  always #5 clk = ~clk;

  assign sio_in = loop_en ? sio_out : sio_drv;

  pokey_sio_link #(.BAUD_DIV(DIV)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tx_data_i      (tx_data),
    .tx_rdy_i       (tx_rdy),
    .tx_ack_o       (tx_ack),
    .tx_busy_o      (tx_busy),
    .sio_out_o      (sio_out),
    .sio_in_i       (sio_in),
    .rx_data_o      (rx_data),
    .rx_rdy_o       (rx_rdy),
    .rx_ack_i       (rx_ack),
    .rx_frame_err_o (rx_ferr),
    .rx_overrun_o   (rx_ovr)
  );

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  always @(negedge clk) begin
    if (rx_ferr === 1'b1) ferr_cnt++;
    if (rx_ovr === 1'b1) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx_rdy(input string name, input int budget);
    int k = 0;
    while (rx_rdy !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(rx_rdy), 32'd1);
  endtask

  task automatic wait_tx_idle(input string name, input int budget);
    int k = 0;
    while (tx_busy !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(tx_busy), 32'd0);
  endtask

  task automatic send_tx(input logic [7:0] d);
    tx_data = d;
    tx_rdy  = 1'b1;
    tick(1);
    tx_rdy  = 1'b0;
  endtask

  // Drive a raw 8N1 frame on the RX pin with a chosen stop-bit level.
  task automatic send_raw(input logic [7:0] d, input logic stop_bit);
    sio_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      sio_drv = d[i];
      tick(DIV);
    end
    sio_drv = stop_bit;
    tick(DIV);
    sio_drv = 1'b1;
    tick(2 * DIV);
  endtask

  typedef struct {
    logic       rdy;
    logic [7:0] dat;
    logic       ack;
    logic       busy;
    logic       sio;
  } vec_t;

  vec_t vecs[$];
  logic a5_seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic exp_3c [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int f0;
    int o0;

    // 0xA5 frame, one record per clock; tx_data changes after acceptance.
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0});
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < DIV; c++)
        if (!(b == 0 && c == 0))
          vecs.push_back('{1'b0, 8'h5A, 1'b0, 1'b1, a5_seq[b]});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

    rst_n   = 1'b0;
    tx_data = 8'h00;
    tx_rdy  = 1'b0;
    sio_drv = 1'b1;
    loop_en = 1'b0;
    rx_ack  = 1'b0;
    #12;
    check("rst_sio",     32'(sio_out), 32'd1);
    check("rst_busy",    32'(tx_busy), 32'd0);
    check("rst_ack",     32'(tx_ack),  32'd0);
    check("rst_rx_rdy",  32'(rx_rdy),  32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_pulses",  32'({rx_ferr, rx_ovr}), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of a frame.
    send_tx(8'h00);
    tick(10);
    check("mid_busy", 32'(tx_busy), 32'd1);
    check("mid_sio",  32'(sio_out), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sio",  32'(sio_out), 32'd1);
    check("arst_busy", 32'(tx_busy), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single frame from the table, also shows post-reset acceptance.
    foreach (vecs[i]) begin
      tx_rdy  = vecs[i].rdy;
      tx_data = vecs[i].dat;
      tick(1);
      check($sformatf("v%0d_ack", i),  32'(tx_ack),  32'(vecs[i].ack));
      check($sformatf("v%0d_busy", i), 32'(tx_busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_sio", i),  32'(sio_out), 32'(vecs[i].sio));
    end

    // Back-to-back: next byte offered during the stop bit of frame 1.
    send_tx(8'h81);
    tick(36);
    check("b2b_stop_sio",  32'(sio_out), 32'd1);
    check("b2b_stop_busy", 32'(tx_busy), 32'd1);
    tx_data = 8'h3C;
    tx_rdy  = 1'b1;
    tick(3);
    check("b2b_stop_end_ack",  32'(tx_ack),  32'd0);
    check("b2b_stop_end_busy", 32'(tx_busy), 32'd1);
    tick(1);
    check("b2b_idle_busy", 32'(tx_busy), 32'd0);
    check("b2b_idle_sio",  32'(sio_out), 32'd1);
    tick(1);
    check("b2b_ack",  32'(tx_ack),  32'd1);
    check("b2b_busy", 32'(tx_busy), 32'd1);
    check("b2b_start", 32'(sio_out), 32'd0);
    tx_rdy = 1'b0;
    tick(1);
    check("b2b_ack_pulse", 32'(tx_ack), 32'd0);
    tick(4);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_bit%0d", k), 32'(sio_out), 32'(exp_3c[k]));
      tick(4);
    end
    check("b2b_stop2", 32'(sio_out), 32'd1);
    tick(4);
    check("b2b_done", 32'(tx_busy), 32'd0);

    // Loopback receive.
    loop_en = 1'b1;
    tick(2);
    f0 = ferr_cnt;
    send_tx(8'h5A);
    wait_rx_rdy("lb_rdy", 100);
    check("lb_data", 32'(rx_data), 32'h5A);
    check("lb_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    rx_ack = 1'b1;
    tick(1);
    check("lb_ack_clr", 32'(rx_rdy), 32'd0);
    rx_ack = 1'b0;
    tick(1);
    check("lb_stay_clr", 32'(rx_rdy), 32'd0);

    // Overrun: second byte without an ack.
    wait_tx_idle("ovr_idle0", 100);
    o0 = ovr_cnt;
    send_tx(8'h11);
    wait_rx_rdy("ovr_rdy1", 100);
    check("ovr_data1", 32'(rx_data), 32'h11);
    wait_tx_idle("ovr_idle1", 100);
    send_tx(8'h22);
    tick(60);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_keep",   32'(rx_data), 32'h11);
    check("ovr_rdy",    32'(rx_rdy),  32'd1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check("ovr_clr", 32'(rx_rdy), 32'd0);

    // Frame error: stop bit held low.
    loop_en = 1'b0;
    sio_drv = 1'b1;
    tick(4);
    f0 = ferr_cnt;
    send_raw(8'h77, 1'b0);
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_rdy",   32'(rx_rdy),  32'd0);
    check("ferr_data",  32'(rx_data), 32'h11);

    // One-cycle glitch, then a good frame to show RX recovered.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    sio_drv = 1'b0;
    tick(1);
    sio_drv = 1'b1;
    tick(20);
    check("glitch_rdy",  32'(rx_rdy), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_ovr",  32'(ovr_cnt - o0), 32'd0);
    send_raw(8'hC3, 1'b1);
    check("raw_rdy",  32'(rx_rdy),  32'd1);
    check("raw_data", 32'(rx_data), 32'hC3);
    rx_ack = 1'b1;
    tick(1);
    check("raw_clr", 32'(rx_rdy), 32'd0);

    // Ack still high when a good byte lands: it is an overrun, rdy stays low.
    o0 = ovr_cnt;
    send_raw(8'h99, 1'b1);
    check("ackhi_rdy",  32'(rx_rdy),  32'd0);
    check("ackhi_ovr",  32'(ovr_cnt - o0), 32'd1);
    check("ackhi_data", 32'(rx_data), 32'hC3);
    rx_ack = 1'b0;
    tick(2);
    check("ackhi_after", 32'(rx_rdy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
